dac_spi_tx: RTL

DAC_SPI_TX -- requirements
Module: dac_spi_tx

---
 rtl/dac_spi_tx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dac_spi_tx.sv
// Serial transmitter for a 12-bit SPI DAC: a sample is converted to offset binary, framed as
// {2'b00, sample, 2'b00} and shifted MSB first, with a single-entry holding register for the next sample.
module dac_spi_tx #(
    parameter int DAC_DATA_WIDTH   = 12,
    parameter int SCLK_HALF_PERIOD = 1,
    parameter int SYNC_GAP         = 2
) (
    input  logic                             CLK,
    input  logic                             RESET_N,
    input  logic                             CE,
    input  logic signed [DAC_DATA_WIDTH-1:0] DAC_VALUE,
    input  logic                             DAC_VALUE_WE,
    output logic                             READY,
    output logic                             DAC_SYNC_N,
    output logic                             DAC_SCLK,
    output logic                             DAC_SDO,
    output logic                             FRAME_DONE,
    output logic                             OVERRUN
);

    localparam int FRAME_W = DAC_DATA_WIDTH + 4;
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(FRAME_W - 1);
    localparam logic [7:0]       HALF_MAX = 8'(SCLK_HALF_PERIOD - 1);
    localparam logic [7:0]       GAP_MAX  = 8'(SYNC_GAP - 1);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_t;

    state_t             r_state,     w_state_nxt;
    logic [FRAME_W-1:0] r_shift,     w_shift_nxt;
    logic [FRAME_W-1:0] r_hold,      w_hold_nxt;
    logic               r_hold_full, w_hold_full_nxt;
    logic [7:0]         r_half_cnt,  w_half_nxt;
    logic [BIT_W-1:0]   r_bit_cnt,   w_bit_nxt;
    logic               r_phase,     w_phase_nxt;
    logic [7:0]         r_gap_cnt,   w_gap_nxt;
    logic               r_sync_n,    w_sync_nxt;
    logic               r_sclk,      w_sclk_nxt;
    logic               r_sdo,       w_sdo_nxt;
    logic               r_frame_done, w_fd_nxt;
    logic               r_overrun,   w_ovr_nxt;

    logic               w_we;
    logic               w_accept;
    logic               w_load;
    logic [FRAME_W-1:0] w_word;
    logic [FRAME_W-1:0] w_load_word;

    assign w_we     = CE & DAC_VALUE_WE;
    assign w_accept = w_we & ~r_hold_full;
    // Offset binary: invert the sign bit, pad two zero bits on each side.
    assign w_word   = {2'b00, ~DAC_VALUE[DAC_DATA_WIDTH-1], DAC_VALUE[DAC_DATA_WIDTH-2:0], 2'b00};

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_half_nxt      = r_half_cnt;
        w_bit_nxt       = r_bit_cnt;
        w_phase_nxt     = r_phase;
        w_gap_nxt       = r_gap_cnt;
        w_sync_nxt      = r_sync_n;
        w_sclk_nxt      = r_sclk;
        w_sdo_nxt       = r_sdo;
        w_fd_nxt        = 1'b0;
        w_ovr_nxt       = r_overrun | (w_we & r_hold_full);
        w_load          = 1'b0;
        w_load_word     = w_word;

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_load = 1'b1;
                end
            end
            StShift: begin
                if (w_accept) begin
                    w_hold_nxt      = w_word;
                    w_hold_full_nxt = 1'b1;
                end
                if (r_half_cnt == HALF_MAX) begin
                    w_half_nxt = 8'd0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                        w_sclk_nxt  = 1'b0;
                    end else if (r_bit_cnt == BIT_MAX) begin
                        w_state_nxt = StGap;
                        w_sync_nxt  = 1'b1;
                        w_sclk_nxt  = 1'b1;
                        w_sdo_nxt   = 1'b0;
                        w_fd_nxt    = 1'b1;
                        w_gap_nxt   = 8'd0;
                    end else begin
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                        w_phase_nxt = 1'b0;
                        w_sclk_nxt  = 1'b1;
                        w_sdo_nxt   = r_shift[FRAME_W-1];
                        w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
                    end
                end else begin
                    w_half_nxt = r_half_cnt + 8'd1;
                end
            end
            StGap: begin
                if (r_gap_cnt == GAP_MAX) begin
                    // A full holding register wins; a write on this edge is then dropped.
                    if (r_hold_full) begin
                        w_load          = 1'b1;
                        w_load_word     = r_hold;
                        w_hold_full_nxt = 1'b0;
                    end else if (w_accept) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt + 8'd1;
                    if (w_accept) begin
                        w_hold_nxt      = w_word;
                        w_hold_full_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        if (w_load) begin
            w_state_nxt = StShift;
            w_shift_nxt = {w_load_word[FRAME_W-2:0], 1'b0};
            w_sdo_nxt   = w_load_word[FRAME_W-1];
            w_sync_nxt  = 1'b0;
            w_sclk_nxt  = 1'b1;
            w_half_nxt  = 8'd0;
            w_bit_nxt   = '0;
            w_phase_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= StIdle;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_half_cnt   <= 8'd0;
            r_bit_cnt    <= '0;
            r_phase      <= 1'b0;
            r_gap_cnt    <= 8'd0;
            r_sync_n     <= 1'b1;
            r_sclk       <= 1'b1;
            r_sdo        <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (CE) begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_full  <= w_hold_full_nxt;
            r_half_cnt   <= w_half_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_phase      <= w_phase_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_sync_n     <= w_sync_nxt;
            r_sclk       <= w_sclk_nxt;
            r_sdo        <= w_sdo_nxt;
            r_frame_done <= w_fd_nxt;
            r_overrun    <= w_ovr_nxt;
        end
    end

    assign READY      = ~r_hold_full;
    assign DAC_SYNC_N = r_sync_n;
    assign DAC_SCLK   = r_sclk;
    assign DAC_SDO    = r_sdo;
    assign FRAME_DONE = r_frame_done;
    assign OVERRUN    = r_overrun;

endmodule
